data_memory_controller: RTL

- Responder end of the LSU data-memory valid/ready protocol.
- Sits between the per-thread LSUs of a core and a single-ported data memory held inside this block.
- Accepts at most one read or write request per grant and arbitrates consumers round-robin.
- Models a fixed access latency, returns a one-cycle ready pulse (with data for reads), then waits for the requester to drop valid before re-arming that consumer.

---
 rtl/data_memory_controller_pkg.sv | 31 +++
 rtl/data_memory_controller_rr_arbiter.sv | 36 +++
 rtl/data_memory_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_controller_pkg.sv
// Shared types for the data-memory controller and its round-robin arbiter.
// Optional out-of-range checking in the controller is enabled by DATA_MEM_OOB_CHECK_EN.
package data_memory_controller_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] data_memory_address_t;

  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_BUSY    = 2'd1,
    CTRL_RESPOND = 2'd2
  } mem_ctrl_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Index after idx in a ring of n entries.
  function automatic int next_rr_index(input int idx, input int n);
    if (idx + 32'sd1 >= n) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/data_memory_controller_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around. Shared with the instruction fetcher.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     request,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_index,
  output logic             any_grant
);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             take_s;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    take_s      = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s       = {1'b0, pointer} + (PTR_W+1)'(i);
      idx_s       = (sum_s >= (PTR_W+1)'(N)) ? PTR_W'(sum_s - (PTR_W+1)'(N)) : PTR_W'(sum_s);
      take_s      = !any_grant && request[idx_s];
      grant[idx_s] = take_s;
      grant_index = take_s ? idx_s : grant_index;
      any_grant   = any_grant | take_s;
    end
  end

endmodule

// File: rtl/data_memory_controller.sv
// Responder for the LSU data-memory valid/ready protocol with an internal
// single-ported memory. Define DATA_MEM_OOB_CHECK_EN to flag/suppress accesses at or beyond DEPTH.
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 32,
  parameter int DEPTH         = 256,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 oob_error
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  mem_ctrl_state_t state_r, next_state_s;

  logic [ADDR_BITS-1:0] rd_addr_a_s [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_a_s [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_a_s [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_r   [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0] pending_s, grant_onehot_s, served_r, served_nxt_s;
  logic [NUM_CONSUMERS-1:0] read_ready_r, write_ready_r;
  logic [PTR_W-1:0]         rr_ptr_r, grant_idx_s, cap_idx_r;
  logic                     any_grant_s, grant_load_s, respond_s;
  mem_op_t                  cap_op_r;
  logic [ADDR_BITS-1:0]     cap_addr_r;
  logic [DATA_BITS-1:0]     cap_data_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     oob_r, oob_s, mem_we_s;
  logic [IDX_W-1:0]         mem_idx_s;
  logic [DATA_BITS-1:0]     mem_rdata_s;
  logic [DATA_BITS-1:0]     mem_r [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_port
      assign rd_addr_a_s[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_a_s[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data_a_s[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data_r[gi];
    end
  endgenerate

  assign pending_s = (consumer_read_valid | consumer_write_valid) & ~served_r;

  rr_arbiter #(
    .N     (NUM_CONSUMERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .request     (pending_s),
    .pointer     (rr_ptr_r),
    .grant       (grant_onehot_s),
    .grant_index (grant_idx_s),
    .any_grant   (any_grant_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= CTRL_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    next_state_s = state_r;
    grant_load_s = 1'b0;
    respond_s    = 1'b0;
    case (state_r)
      CTRL_IDLE: begin
        if (any_grant_s) begin
          next_state_s = CTRL_BUSY;
          grant_load_s = 1'b1;
        end else begin
          next_state_s = CTRL_IDLE;
        end
      end
      CTRL_BUSY: begin
        if (cnt_r == '0) begin
          next_state_s = CTRL_RESPOND;
        end else begin
          next_state_s = CTRL_BUSY;
        end
      end
      CTRL_RESPOND: begin
        respond_s    = 1'b1;
        next_state_s = CTRL_IDLE;
      end
      default: begin
        next_state_s = CTRL_IDLE;
      end
    endcase
  end

  // A served consumer is re-armed only once it has dropped both valids.
  always_comb begin
    served_nxt_s = served_r;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (respond_s && (cap_idx_r == PTR_W'(i))) begin
        served_nxt_s[i] = 1'b1;
      end else if (!consumer_read_valid[i] && !consumer_write_valid[i]) begin
        served_nxt_s[i] = 1'b0;
      end else begin
        served_nxt_s[i] = served_r[i];
      end
    end
  end

`ifdef DATA_MEM_OOB_CHECK_EN
  assign oob_s = (32'(cap_addr_r) >= 32'(DEPTH));
`else
  assign oob_s = 1'b0;
`endif

  assign mem_idx_s   = IDX_W'(cap_addr_r);
  assign mem_rdata_s = oob_s ? '0 : mem_r[mem_idx_s];
  assign mem_we_s    = respond_s && (cap_op_r == OP_WRITE) && !oob_s;

  // Memory array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= cap_data_r;
    end
  end

  // Request capture, latency counter, round-robin pointer and served mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_idx_r  <= '0;
      cap_op_r   <= OP_READ;
      cap_addr_r <= '0;
      cap_data_r <= '0;
      cnt_r      <= '0;
      rr_ptr_r   <= '0;
      served_r   <= '0;
    end else begin
      served_r <= served_nxt_s;
      if (grant_load_s) begin
        cap_idx_r  <= grant_idx_s;
        cap_op_r   <= (|(consumer_read_valid & grant_onehot_s)) ? OP_READ : OP_WRITE;
        cap_addr_r <= (|(consumer_read_valid & grant_onehot_s)) ? rd_addr_a_s[grant_idx_s]
                                                                 : wr_addr_a_s[grant_idx_s];
        cap_data_r <= wr_data_a_s[grant_idx_s];
        cnt_r      <= CNT_W'(MEM_LATENCY - 1);
        rr_ptr_r   <= PTR_W'(next_rr_index(int'(grant_idx_s), NUM_CONSUMERS));
      end else if ((state_r == CTRL_BUSY) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  // Registered completion pulses, read data and sticky range error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_ready_r  <= '0;
      write_ready_r <= '0;
      oob_r         <= 1'b0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rd_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        read_ready_r[i]  <= respond_s && (cap_op_r == OP_READ)  && (cap_idx_r == PTR_W'(i));
        write_ready_r[i] <= respond_s && (cap_op_r == OP_WRITE) && (cap_idx_r == PTR_W'(i));
        if (respond_s && (cap_op_r == OP_READ) && (cap_idx_r == PTR_W'(i))) begin
          rd_data_r[i] <= mem_rdata_s;
        end
      end
      if (respond_s && oob_s) begin
        oob_r <= 1'b1;
      end
    end
  end

  assign consumer_read_ready  = read_ready_r;
  assign consumer_write_ready = write_ready_r;
  assign oob_error            = oob_r;

endmodule
